// File: rtl/uart_tx_arb.sv
// uart_tx_arb: shares one uart_tx among NREQ byte sources (0 = echo, 1 = debug, 2 = ID) via per-source holding registers.
// Latency: strobe at edge k -> pend at k+1 -> launch (strt_tx/tx_data/gnt) registered at edge k+1 when IDLE.
// Backpressure: one byte held per source; a strobe into an occupied holder is dropped and flagged sticky in ovf.
// Option: define UART_TX_ARB_FIXED_PRIO_EN for fixed lowest-index-wins arbitration instead of round-robin.
module uart_tx_arb #(
  parameter int unsigned      NREQ    = 3,
  parameter int unsigned      TMO_W   = 16,
  parameter logic [TMO_W-1:0] TMO_CYC = 16'd60000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   pend,
  output logic [NREQ-1:0]   ovf,
  input  logic              clr_ovf,
  output logic              tmo,
  output logic              strt_tx,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [NREQ-1:0]   gnt
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       hold_q [NREQ];
  logic [NREQ-1:0]  pend_q;
  logic [NREQ-1:0]  ovf_q;
  logic [NREQ-1:0]  gnt_q;
  logic             tmo_q;
  logic             strt_q;
  logic [7:0]       tx_data_q;
  logic [IDX_W-1:0] last_q;
  logic [TMO_W-1:0] wd_q;

  logic             sel_vld;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic [NREQ-1:0]  sel_oh;
  logic [NREQ-1:0]  launch_oh;
  logic             launch;
  logic             done_evt;
  logic             tmo_evt;

  // Pick the winning pending holder; the last write in the loop is the winner.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      cand = IDX_W'(k);
      if (pend_q[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
`else
    for (int k = int'(NREQ); k >= 1; k--) begin
      cand = IDX_W'((int'(last_q) + k) % int'(NREQ));
      if (pend_q[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
`endif
  end

  // One-hot form of the winner, and the same gated by an actual launch.
  always_comb begin
    sel_oh          = '0;
    sel_oh[sel_idx] = sel_vld;
    launch_oh       = launch ? sel_oh : '0;
  end

  // Next-state and launch/complete/abort events; tx_done is ignored while strt_tx is high.
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    done_evt = 1'b0;
    tmo_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_vld) begin
          launch  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!strt_q && tx_done) begin
          done_evt = 1'b1;
          state_d  = IDLE;
        end else if (wd_q == TMO_CYC - 1'b1) begin
          tmo_evt = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Holding registers: capture into a free (or currently launching) slot, otherwise flag the drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) hold_q[i] <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      if (clr_ovf) ovf_q <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        if (req[i] && (!pend_q[i] || launch_oh[i])) begin
          hold_q[i] <= req_data[8*i +: 8];
          pend_q[i] <= 1'b1;
        end else if (req[i]) begin
          ovf_q[i]  <= 1'b1;
        end else if (launch_oh[i]) begin
          pend_q[i] <= 1'b0;
        end
      end
    end
  end

  // Launch datapath, grant tracking, round-robin pointer and transmit watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strt_q    <= 1'b0;
      tx_data_q <= '0;
      gnt_q     <= '0;
      last_q    <= IDX_W'(NREQ - 1);
      wd_q      <= '0;
      tmo_q     <= 1'b0;
    end else begin
      strt_q <= launch;
      if (launch) begin
        tx_data_q <= hold_q[sel_idx];
        gnt_q     <= sel_oh;
        last_q    <= sel_idx;
        wd_q      <= '0;
      end else if (state_q == SEND) begin
        wd_q <= wd_q + 1'b1;
        if (done_evt || tmo_evt) gnt_q <= '0;
      end
      if (tmo_evt)      tmo_q <= 1'b1;
      else if (clr_ovf) tmo_q <= 1'b0;
    end
  end

  assign pend    = pend_q;
  assign ovf     = ovf_q;
  assign tmo     = tmo_q;
  assign strt_tx = strt_q;
  assign tx_data = tx_data_q;
  assign gnt     = gnt_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: directed bench for uart_tx_arb with a short watchdog period.
// Latency: inputs driven 1 ns after each rising edge, outputs sampled at the same point.
// Backpressure: a hand-driven tx_done stands in for the uart_tx completion.
module tb_uart_tx_arb;

  localparam int unsigned NREQ = 3;
  localparam logic [15:0] TMO  = 16'd200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [23:0] req_data;
  logic [2:0]  pend;
  logic [2:0]  ovf;
  logic        clr_ovf;
  logic        tmo;
  logic        strt_tx;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic [2:0]  gnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_arb #(
    .NREQ    (NREQ),
    .TMO_W   (16),
    .TMO_CYC (TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .pend     (pend),
    .ovf      (ovf),
    .clr_ovf  (clr_ovf),
    .tmo      (tmo),
    .strt_tx  (strt_tx),
    .tx_data  (tx_data),
    .tx_done  (tx_done),
    .gnt      (gnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    clr_ovf  = 1'b0;
    tx_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Advance until a launch is visible (bounded), then check the launched byte and grant.
  task automatic wait_launch(input string tag, input logic [7:0] exp_d, input logic [2:0] exp_g);
    int n = 0;
    while (!strt_tx && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_strt"}, strt_tx, 1);
    chk({tag, "_data"}, tx_data, exp_d);
    chk({tag, "_gnt"},  gnt,     exp_g);
  endtask

  // Completion pulse sampled on the cyc-th edge after the launch.
  task automatic ack(input int cyc);
    repeat (cyc - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_pend", pend, 3'b000);
    chk("rst_ovf",  ovf,  3'b000);
    chk("rst_gnt",  gnt,  3'b000);
    chk("rst_strt", strt_tx, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_tmo",  tmo, 0);

    // Single byte on requester 1
    req = 3'b010; req_data = 24'h00A500;
    tick();
    req = '0;
    chk("t1_pend", pend, 3'b010);
    chk("t1_nostrt", strt_tx, 0);
    tick();
    chk("t1_strt", strt_tx, 1);
    chk("t1_data", tx_data, 8'hA5);
    chk("t1_gnt",  gnt, 3'b010);
    chk("t1_pend0", pend, 3'b000);
    tick();
    chk("t1_strt_once", strt_tx, 0);
    chk("t1_gnt_hold", gnt, 3'b010);
    repeat (8) tick();
    tx_done = 1'b1;
    tick();
    chk("t1_gnt_done", gnt, 3'b000);
    tick();
    tick();
    tx_done = 1'b0;
    chk("t1_idle_done", strt_tx, 0);
    chk("t1_idle_gnt", gnt, 3'b000);

    // All three strobed together: served 0, 1, 2
    do_reset();
    req = 3'b111; req_data = 24'h332211;
    tick();
    req = '0;
    chk("t2_pend", pend, 3'b111);
    wait_launch("t2_b0", 8'h11, 3'b001);
    ack(20);
    chk("t2_gnt0", gnt, 3'b000);
    wait_launch("t2_b1", 8'h22, 3'b010);
    ack(20);
    wait_launch("t2_b2", 8'h33, 3'b100);
    ack(20);
    chk("t2_pend_end", pend, 3'b000);

    // Overflow on requester 2 while requester 0 is in flight
    do_reset();
    req = 3'b001; req_data = 24'h000001;
    tick();
    req = '0;
    wait_launch("t3_busy", 8'h01, 3'b001);
    req = 3'b100; req_data = 24'h440000;
    tick();
    req = '0;
    chk("t3_pend", pend, 3'b100);
    chk("t3_noovf", ovf, 3'b000);
    req = 3'b100; req_data = 24'h550000;
    tick();
    req = '0;
    chk("t3_ovf", ovf, 3'b100);
    chk("t3_pend_keep", pend, 3'b100);
    req = 3'b100; req_data = 24'h660000; clr_ovf = 1'b1;
    tick();
    req = '0; clr_ovf = 1'b0;
    chk("t3_set_beats_clr", ovf, 3'b100);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t3_clr", ovf, 3'b000);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t3_gnt_done", gnt, 3'b000);
    wait_launch("t3_b44", 8'h44, 3'b100);
    ack(5);
    repeat (3) tick();
    chk("t3_no55", strt_tx, 0);
    chk("t3_pend_end", pend, 3'b000);

    // Recapture on the launch edge, then a stale tx_done level across the next launch
    do_reset();
    req = 3'b001; req_data = 24'h0000AA;
    tick();
    req = 3'b001; req_data = 24'h0000BB;
    tick();
    req = '0;
    chk("t4_strt", strt_tx, 1);
    chk("t4_data", tx_data, 8'hAA);
    chk("t4_pend", pend, 3'b001);
    chk("t4_noovf", ovf, 3'b000);
    tick();
    tx_done = 1'b1;
    tick();
    chk("t4_gnt_done", gnt, 3'b000);
    wait_launch("t4_bb", 8'hBB, 3'b001);
    tick();
    chk("t5_stale_ignored", gnt, 3'b001);
    tx_done = 1'b0;
    repeat (3) tick();
    chk("t5_gnt_wait", gnt, 3'b001);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("t5_gnt_done", gnt, 3'b000);

    // Watchdog abort exactly TMO cycles after launch
    do_reset();
    req = 3'b010; req_data = 24'h007700;
    tick();
    req = '0;
    wait_launch("t6", 8'h77, 3'b010);
    repeat (int'(TMO) - 1) tick();
    chk("t6_tmo_early", tmo, 0);
    chk("t6_gnt_early", gnt, 3'b010);
    tick();
    chk("t6_tmo", tmo, 1);
    chk("t6_gnt", gnt, 3'b000);
    tick();
    chk("t6_noretry", strt_tx, 0);
    chk("t6_pend", pend, 3'b000);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t6_tmo_clr", tmo, 0);

    // Asynchronous reset in the middle of a send
    do_reset();
    req = 3'b011; req_data = 24'h002211;
    tick();
    req = '0;
    wait_launch("t7", 8'h11, 3'b001);
    tick();
    tick();
    chk("t7_pend_pre", pend, 3'b010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_gnt",  gnt, 3'b000);
    chk("t7_pend", pend, 3'b000);
    chk("t7_data", tx_data, 8'h00);
    chk("t7_strt", strt_tx, 0);
    chk("t7_ovf",  ovf, 3'b000);
    chk("t7_tmo",  tmo, 0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Arbiter and sequencer that shares the single uart_tx transmitter among several on-chip byte sources: command echo, debug data (dbg_data/dbg_tx) and barcode station ID report.
- Each requester strobes a byte into a private holding register.
- The block picks one pending byte, launches it with strt_tx/tx_data, then waits for tx_done before the next launch.
- Sits in the follower top between dig_core / barcode / command path and the uart_tx instance.

Parameters:
- NREQ, 3, number of requesters; index 0 = echo, 1 = debug, 2 = ID.
- TMO_W, 16, width of the transmit watchdog counter.
- TMO_CYC, 16'd60000, cycles in SEND without tx_done before abort (1 byte at 9600 baud / 50 MHz is about 52k cycles).

Ports:
- clk  input  1  50 MHz system clock
- rst_n  input  1  asynchronous active-low reset (already synchronized at top)
- req  input  NREQ  per-requester single-cycle byte strobe
- req_data  input  8*NREQ  byte for requester i at bits [8i+7:8i]; valid when req[i]=1
- pend  output  NREQ  holding register i occupied (requester busy indication)
- ovf  output  NREQ  sticky: strobe on requester i was dropped
- clr_ovf  input  1  clears all ovf bits
- tmo  output  1  sticky: a transmit was aborted by watchdog; cleared by clr_ovf
- strt_tx  output  1  one-cycle launch pulse to uart_tx
- tx_data  output  8  byte to uart_tx; registered, stable from launch until next launch
- tx_done  input  1  uart_tx completion; level or pulse accepted
- gnt  output  NREQ  one-hot: requester whose byte is in flight; 0 when idle

Behaviour:
- Reset: all outputs 0, holding registers 0, state IDLE, round-robin pointer last = NREQ-1 (so index 0 wins first).
- Capture, per i, at each posedge:
  - If req[i] and (!pend[i] or i is being launched this edge): hold[i] <= byte, pend[i] <= 1.
  - Else if req[i] and pend[i]: byte dropped, hold[i] unchanged, ovf[i] <= 1.
- clr_ovf clears ovf and tmo. A set event on the same edge wins over clr_ovf.
- FSM:
  - IDLE: if any pend, choose g = first pending index after last, modulo NREQ.
    - On that edge: tx_data <= hold[g], strt_tx <= 1, pend[g] <= 0 (unless recaptured), gnt <= onehot(g), last <= g, watchdog <= 0, go to SEND.
    - If nothing is pending, stay in IDLE with strt_tx = 0.
  - SEND:
    - strt_tx is forced to 0 after its single launch cycle.
    - tx_done is ignored during the first SEND cycle (the cycle strt_tx is high), so a stale level from the previous byte is not taken as completion.
    - Afterwards, tx_done = 1 causes gnt <= 0 and a return to IDLE.
    - Watchdog increments each SEND cycle. When it reaches TMO_CYC-1 without tx_done: tmo <= 1, gnt <= 0, go to IDLE. The byte is lost and is not retried.
- Latency:
  - A req captured at edge k is visible as pend at k+1.
  - If the FSM is IDLE, strt_tx is high in the cycle after edge k+1.
  - Minimum spacing between launches: launch, at least 2 SEND cycles, then IDLE evaluates on the next edge, giving at least 3 cycles in practice.
- Fairness: with all requesters continuously pending, grants rotate 0,1,2,0,...
- tx_done seen in IDLE has no effect. req with NREQ bits simultaneously set captures all of them independently.
- Reset mid-SEND aborts immediately. All pending bytes are discarded, and uart_tx is expected to be reset by the same rst_n.

Optional Feature:
- Macro: UART_TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest pending index always wins. The last pointer is still maintained but unused.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both modes.

Test Plan:
- Reset, then req[1] with data 8'hA5 at cycle 0 -> pend[1] = 1 at cycle 1; strt_tx = 1 for exactly one cycle at cycle 2 with tx_data = 8'hA5 and gnt = 3'b010; tx_done after 10 cycles -> gnt = 0, FSM back to IDLE.
- req = 3'b111 with data 8'h11/8'h22/8'h33 in one cycle; uart model acks each byte after 20 cycles -> launches in order 8'h11, 8'h22, 8'h33. With UART_TX_ARB_FIXED_PRIO_EN, refill req[0] during each send -> index 0 is always served and index 2 starves.
- req[2] = 8'h44, then req[2] = 8'h55 while the first byte is still pending before its launch -> ovf[2] = 1 and only 8'h44 is transmitted. Then clr_ovf -> ovf = 0.
- req[0] asserted on the same edge as its own launch -> no overflow; pend[0] stays 1 and the new byte is sent next.
- tx_done held high from the previous byte, then a new launch -> no premature return to IDLE; completion is taken only on tx_done after the launch cycle.
- No tx_done for TMO_CYC cycles -> tmo = 1, gnt = 0, FSM in IDLE. Assert rst_n low mid-SEND -> all outputs 0 asynchronously.
